// File: rtl/ic_sparse_mac_if.sv
// Result stream of ic_sparse_mac: one accumulated dot product per kernel,
// transferred on valid && ready.
interface ic_sparse_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
);
    logic                  valid;
    logic                  ready;
    logic [ACC_WIDTH-1:0]  data;
    logic [DATA_WIDTH-1:0] kidx;

    modport master (
        output valid,
        output data,
        output kidx,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  kidx,
        output ready
    );
endinterface

// File: rtl/ic_sparse_mac.sv
// Sparse MAC behind the P-to-IC compressor: scans one C/I slot per cycle
// into K accumulators through a single multiplier, then streams the K sums.
module ic_sparse_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int S          = 3,
    parameter int KH         = 3,
    parameter int KW         = 3,
    parameter int K          = 10,
    parameter int ACC_WIDTH  = 21
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic                             start,
    input  logic [S*KH*KW*DATA_WIDTH-1:0]    c_flat,
    input  logic [S*KH*KW*DATA_WIDTH-1:0]    i_flat,
    input  logic [KH*KW*DATA_WIDTH-1:0]      act_flat,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    ic_sparse_mac_if.master                  res
);
    localparam int DW = DATA_WIDTH;
    localparam int NP = KH * KW;
    localparam int NS = S * NP;
    localparam int JW = (NS > 1) ? $clog2(NS) : 1;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int NW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DW-1:0]        c_q   [NS];
    logic [DW-1:0]        i_q   [NS];
    logic [DW-1:0]        act_q [NP];
    logic [ACC_WIDTH-1:0] acc   [K];

    logic [JW-1:0]   j;
    logic [PW-1:0]   pos;
    logic [NW-1:0]   n;
    logic            accept;
    logic            xfer;
    logic            last_slot;
    logic            last_k;
    logic [DW-1:0]   idx;
    logic [2*DW-1:0] prod;

    // A start landing on the done cycle is dropped, not queued.
    assign accept    = (state == IDLE) && start && !done;
    assign xfer      = res.valid && res.ready;
    assign last_slot = (j == JW'(NS - 1));
    assign last_k    = (n == NW'(K - 1));
    assign idx       = i_q[j];
    assign prod      = (2*DW)'(c_q[j]) * (2*DW)'(act_q[pos]);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = SCAN;
            SCAN:    if (last_slot) state_nx = EMIT;
            EMIT:    if (xfer && last_k) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        res.valid = (state == EMIT);
        res.data  = '0;
        res.kidx  = '0;
        if (state == EMIT) begin
            res.data = acc[n];
            res.kidx = DW'(n) + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int p = 0; p < NS; p++) begin
                c_q[p] <= '0;
                i_q[p] <= '0;
            end
            for (int p = 0; p < NP; p++) begin
                act_q[p] <= '0;
            end
            for (int k = 0; k < K; k++) begin
                acc[k] <= '0;
            end
            j    <= '0;
            pos  <= '0;
            n    <= '0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == EMIT) && xfer && last_k;
            if (accept) begin
                for (int p = 0; p < NS; p++) begin
                    c_q[p] <= c_flat[p*DW +: DW];
                    i_q[p] <= i_flat[p*DW +: DW];
                end
                for (int p = 0; p < NP; p++) begin
                    act_q[p] <= act_flat[p*DW +: DW];
                end
                for (int k = 0; k < K; k++) begin
                    acc[k] <= '0;
                end
                j   <= '0;
                pos <= '0;
                n   <= '0;
                err <= 1'b0;
            end else if (state == SCAN) begin
                // Index 0 matches no kernel, so empty slots fall through.
                for (int k = 0; k < K; k++) begin
                    if (idx == DW'(k + 1)) begin
                        acc[k] <= acc[k] + ACC_WIDTH'(prod);
                    end
                end
                if (idx > DW'(K)) begin
                    err <= 1'b1;
                end
                j   <= last_slot ? '0 : j + JW'(1);
                pos <= (pos == PW'(NP - 1)) ? '0 : pos + PW'(1);
            end else if (state == EMIT && xfer) begin
                n <= last_k ? '0 : n + NW'(1);
            end
        end
    end
endmodule
